// File: rtl/spi_slave_byte_rx.sv
// SPI mode-0 slave byte receiver with reply shifter, clocked by sysClk.
// Raw SPI pins are oversampled; received bytes are strobed downstream.
module spi_slave_byte_rx #(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 4
) (
   input  logic             sysClk,
   input  logic             sysRst_n,
   input  logic             spi_sck,
   input  logic             spi_cs_n,
   input  logic             spi_mosi,
   output logic             spi_miso,
   output logic             miso_oe,
   input  logic [7:0]       tx_byte,
   output logic             tx_load,
   output logic [7:0]       spi_byte,
   output logic             spi_input_valid,
   output logic             frame_start,
   output logic             frame_end,
   output logic             frame_abort,
   output logic [CNT_W-1:0] frame_byte_cnt
);

   localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   state_t state, state_n;

   logic [NS-1:0] sck_sy;
   logic [NS-1:0] cs_sy;
   logic [NS-1:0] mosi_sy;
   logic          sck_s, cs_s, mosi_s;
   logic          sck_d, cs_d;
   logic          sck_rise_q, sck_fall_q;
   logic          cs_rise_q, cs_fall_q;
   logic          mosi_q;
   logic [NS:0]   warm;
   logic          armed;

   logic          go, stop, rx_ev, tx_ev;
   logic [2:0]    bit_cnt;
   logic [7:0]    rx_shift;
   logic [7:0]    tx_shift;

   assign sck_s  = sck_sy[NS-1];
   assign cs_s   = cs_sy[NS-1];
   assign mosi_s = mosi_sy[NS-1];

   // Only arm after the sync chain has flushed and CS_n is seen high,
   // so a frame already running at reset release is skipped.
   always_ff @(posedge sysClk or negedge sysRst_n) begin
      if (!sysRst_n) begin
         sck_sy     <= '0;
         cs_sy      <= '1;
         mosi_sy    <= '0;
         sck_d      <= 1'b0;
         cs_d       <= 1'b1;
         sck_rise_q <= 1'b0;
         sck_fall_q <= 1'b0;
         cs_rise_q  <= 1'b0;
         cs_fall_q  <= 1'b0;
         mosi_q     <= 1'b0;
         warm       <= '0;
         armed      <= 1'b0;
      end else begin
         sck_sy     <= {sck_sy[NS-2:0], spi_sck};
         cs_sy      <= {cs_sy[NS-2:0], spi_cs_n};
         mosi_sy    <= {mosi_sy[NS-2:0], spi_mosi};
         sck_d      <= sck_s;
         cs_d       <= cs_s;
         sck_rise_q <= sck_s & ~sck_d;
         sck_fall_q <= ~sck_s & sck_d;
         cs_rise_q  <= cs_s & ~cs_d;
         cs_fall_q  <= ~cs_s & cs_d;
         mosi_q     <= mosi_s;
         warm       <= {warm[NS-1:0], 1'b1};
         armed      <= armed | (warm[NS] & cs_s & cs_d);
      end
   end

   always_ff @(posedge sysClk or negedge sysRst_n) begin
      if (!sysRst_n) state <= IDLE;
      else           state <= state_n;
   end

   // CS rise has priority over any SCK edge in the same cycle.
   always_comb begin
      state_n = state;
      go      = 1'b0;
      stop    = 1'b0;
      rx_ev   = 1'b0;
      tx_ev   = 1'b0;
      unique case (state)
         IDLE: begin
            if (cs_fall_q && armed) begin
               state_n = ACTIVE;
               go      = 1'b1;
            end
         end
         ACTIVE: begin
            if (cs_rise_q) begin
               state_n = IDLE;
               stop    = 1'b1;
            end else begin
               rx_ev = sck_rise_q;
               tx_ev = sck_fall_q;
            end
         end
      endcase
   end

   always_ff @(posedge sysClk or negedge sysRst_n) begin
      if (!sysRst_n) begin
         bit_cnt         <= '0;
         rx_shift        <= '0;
         tx_shift        <= '0;
         tx_load         <= 1'b0;
         spi_byte        <= '0;
         spi_input_valid <= 1'b0;
         frame_start     <= 1'b0;
         frame_end       <= 1'b0;
         frame_abort     <= 1'b0;
         frame_byte_cnt  <= '0;
      end else begin
         tx_load         <= 1'b0;
         spi_input_valid <= 1'b0;
         frame_start     <= 1'b0;
         frame_end       <= 1'b0;
         frame_abort     <= 1'b0;
         if (go) begin
            bit_cnt        <= '0;
            frame_byte_cnt <= '0;
            tx_shift       <= tx_byte;
            tx_load        <= 1'b1;
            frame_start    <= 1'b1;
         end
         if (stop) begin
            frame_end   <= 1'b1;
            frame_abort <= (bit_cnt != 3'd0);
            bit_cnt     <= '0;
         end
         if (rx_ev) begin
            rx_shift <= {rx_shift[6:0], mosi_q};
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
               spi_byte        <= {rx_shift[6:0], mosi_q};
               spi_input_valid <= 1'b1;
               if (frame_byte_cnt != '1)
                  frame_byte_cnt <= frame_byte_cnt + CNT_W'(1);
            end
         end
         if (tx_ev) begin
            if (bit_cnt == 3'd0) begin
               tx_shift <= tx_byte;
               tx_load  <= 1'b1;
            end else begin
               tx_shift <= {tx_shift[6:0], 1'b0};
            end
         end
      end
   end

   assign miso_oe  = (state == ACTIVE);
   assign spi_miso = (state == ACTIVE) & tx_shift[7];

endmodule

// File: tb/tb_spi_slave_byte_rx.sv
// Directed bench for spi_slave_byte_rx with a received-byte scoreboard.
// Drives SPI mode 0 at SCK = sysClk/8 and checks strobes, counts and MISO.
module tb_spi_slave_byte_rx;

   localparam int SYNC = 2;
   localparam int CW   = 4;

   logic          sysClk = 1'b0;
   logic          sysRst_n;
   logic          spi_sck, spi_cs_n, spi_mosi;
   logic          spi_miso, miso_oe;
   logic [7:0]    tx_byte;
   logic          tx_load;
   logic [7:0]    spi_byte;
   logic          spi_input_valid;
   logic          frame_start, frame_end, frame_abort;
   logic [CW-1:0] frame_byte_cnt;

   spi_slave_byte_rx #(.SYNC_STAGES(SYNC), .CNT_W(CW)) dut (
      .sysClk          (sysClk),
      .sysRst_n        (sysRst_n),
      .spi_sck         (spi_sck),
      .spi_cs_n        (spi_cs_n),
      .spi_mosi        (spi_mosi),
      .spi_miso        (spi_miso),
      .miso_oe         (miso_oe),
      .tx_byte         (tx_byte),
      .tx_load         (tx_load),
      .spi_byte        (spi_byte),
      .spi_input_valid (spi_input_valid),
      .frame_start     (frame_start),
      .frame_end       (frame_end),
      .frame_abort     (frame_abort),
      .frame_byte_cnt  (frame_byte_cnt)
   );

   always #5 sysClk = ~sysClk;

   typedef struct {
      logic [7:0]    b;
      logic [CW-1:0] c;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   int   last_rise = 0;
   int   n_valid = 0, n_load = 0, n_end = 0, n_abort = 0, n_start = 0;

   always @(posedge sysClk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge sysClk) begin
      if (sysRst_n === 1'b1) begin
         if (spi_input_valid) begin
            n_valid++;
            chk("valid_expected", 32'(sb.size() > 0), 1);
            chk("valid_latency", cyc - last_rise + 1, SYNC + 2);
            if (sb.size() > 0) begin
               exp_t e;
               e = sb.pop_front();
               chk("spi_byte", spi_byte, e.b);
               chk("byte_cnt", frame_byte_cnt, e.c);
            end
         end
         if (tx_load) n_load++;
         if (frame_start) n_start++;
         if (frame_end) n_end++;
         if (frame_abort) begin
            n_abort++;
            chk("abort_with_end", frame_end, 1);
         end
      end
   end

   task automatic send_bits(input logic [7:0] b, input int n,
                            output logic [7:0] mb);
      mb = '0;
      for (int i = 0; i < n; i++) begin
         spi_mosi = b[7-i];
         repeat (4) @(negedge sysClk);
         mb = {mb[6:0], spi_miso};
         last_rise = cyc + 1;
         spi_sck = 1'b1;
         repeat (4) @(negedge sysClk);
         spi_sck = 1'b0;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic [CW-1:0] c,
                            output logic [7:0] mb);
      exp_t e;
      e.b = b;
      e.c = c;
      sb.push_back(e);
      send_bits(b, 8, mb);
   endtask

   task automatic drain(input string tag);
      for (int k = 0; k < 100 && sb.size() != 0; k++)
         @(negedge sysClk);
      chk(tag, sb.size(), 0);
   endtask

   task automatic cs_low();
      spi_cs_n = 1'b0;
      repeat (8) @(negedge sysClk);
   endtask

   task automatic cs_high();
      repeat (8) @(negedge sysClk);
      spi_cs_n = 1'b1;
      repeat (10) @(negedge sysClk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] mb;
      logic [CW-1:0] c;
      int v0, s0;

      sysRst_n = 1'b0;
      spi_sck  = 1'b0;
      spi_cs_n = 1'b1;
      spi_mosi = 1'b0;
      tx_byte  = 8'h00;
      repeat (3) @(negedge sysClk);
      chk("rst_byte", spi_byte, 0);
      chk("rst_valid", spi_input_valid, 0);
      chk("rst_oe", miso_oe, 0);
      chk("rst_miso", spi_miso, 0);
      chk("rst_cnt", frame_byte_cnt, 0);
      chk("rst_pulses", {frame_start, frame_end, frame_abort, tx_load}, 0);
      sysRst_n = 1'b1;
      repeat (10) @(negedge sysClk);

      // 1: three-byte frame
      n_end = 0; n_abort = 0; n_valid = 0;
      cs_low();
      chk("t1_oe", miso_oe, 1);
      send_byte(8'h02, 4'd1, mb);
      send_byte(8'hFF, 4'd2, mb);
      send_byte(8'hFF, 4'd3, mb);
      drain("t1_drain");
      cs_high();
      chk("t1_valids", n_valid, 3);
      chk("t1_end", n_end, 1);
      chk("t1_abort", n_abort, 0);
      chk("t1_cnt_hold", frame_byte_cnt, 3);

      // 2: reply bytes on MISO
      n_load = 0;
      tx_byte = 8'hA5;
      cs_low();
      tx_byte = 8'h3C;
      send_byte(8'h5A, 4'd1, mb);
      chk("t2_miso0", mb, 8'hA5);
      send_byte(8'hC3, 4'd2, mb);
      chk("t2_miso1", mb, 8'h3C);
      drain("t2_drain");
      cs_high();
      chk("t2_loads", n_load, 3);

      // 3: aborted partial byte
      n_end = 0; n_abort = 0; n_valid = 0;
      cs_low();
      send_bits(8'hF0, 5, mb);
      cs_high();
      chk("t3_valids", n_valid, 0);
      chk("t3_abort", n_abort, 1);
      chk("t3_end", n_end, 1);
      cs_low();
      send_byte(8'h3C, 4'd1, mb);
      drain("t3_drain");
      cs_high();
      chk("t3_abort2", n_abort, 1);

      // 4: reset mid-frame, CS still low at release
      cs_low();
      send_bits(8'hAA, 4, mb);
      sysRst_n = 1'b0;
      #1;
      chk("t4_rst_oe", miso_oe, 0);
      chk("t4_rst_cnt", frame_byte_cnt, 0);
      repeat (3) @(negedge sysClk);
      sysRst_n = 1'b1;
      v0 = n_valid;
      s0 = n_start;
      repeat (10) @(negedge sysClk);
      send_bits(8'hFF, 8, mb);
      repeat (10) @(negedge sysClk);
      chk("t4_ignored_valid", n_valid, v0);
      chk("t4_ignored_start", n_start, s0);
      chk("t4_ignored_oe", miso_oe, 0);
      cs_high();
      cs_low();
      send_byte(8'h81, 4'd1, mb);
      drain("t4_drain");
      cs_high();

      // 5: counter saturation
      n_valid = 0;
      cs_low();
      for (int i = 0; i < 17; i++) begin
         c = (i + 1 > 15) ? CW'(15) : CW'(i + 1);
         send_byte(8'(i * 29 + 7), c, mb);
      end
      drain("t5_drain");
      cs_high();
      chk("t5_valids", n_valid, 17);
      chk("t5_cnt_sat", frame_byte_cnt, 15);

      // 6: SCK activity with CS high
      n_valid = 0;
      spi_mosi = 1'b1;
      for (int i = 0; i < 16; i++) begin
         spi_sck = 1'b1;
         repeat (4) @(negedge sysClk);
         spi_sck = 1'b0;
         repeat (4) @(negedge sysClk);
         if (i % 4 == 0) begin
            chk("t6_oe", miso_oe, 0);
            chk("t6_miso", spi_miso, 0);
         end
      end
      repeat (10) @(negedge sysClk);
      chk("t6_valids", n_valid, 0);
      chk("t6_cnt", frame_byte_cnt, 15);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
